// File: rtl/wr_burst_sched_if.sv
// AXI write-address and write-response channels of the encoder output path.
// The scheduler drives through master; the memory side sees slave.
interface wr_burst_sched_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, bready,
        input  awready, bvalid, bresp
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid, bready,
        output awready, bvalid, bresp
    );
endinterface

// File: rtl/wr_burst_sched.sv
// Issues one fixed-length AW burst per macroblock, caps bursts in flight,
// and pulses done once every burst of the frame has a B response.
module wr_burst_sched #(
    parameter int ADDR_W      = 64,
    parameter int BURST_BEATS = 7,
    parameter int BEAT_BYTES  = 128,
    parameter int MAX_OUTST   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_pulse,
    input  logic [31:0]       mb_w,
    input  logic [31:0]       mb_h,
    input  logic [ADDR_W-1:0] base_addr,
    wr_burst_sched_if.master  m_axi,
    output logic              busy,
    output logic              done_pulse,
    output logic              resp_err
);
    localparam int          STRIDE = BURST_BEATS * BEAT_BYTES;
    localparam logic [7:0]  AWLEN  = 8'(BURST_BEATS - 1);
    localparam logic [2:0]  AWSIZE = 3'($clog2(BEAT_BYTES));
    localparam logic [7:0]  MAXO   = 8'(MAX_OUTST);

    typedef enum logic [2:0] {
        IDLE, INIT, ISSUE, DRAIN, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [21:0]       total_q, total_d;
    logic [21:0]       iss_q, iss_d;
    logic [21:0]       cmp_q, cmp_d;
    logic [7:0]        out_q, out_d;
    logic              err_q, err_d;
    logic              awv_q, awv_d;
    logic              busy_q, done_q;
    logic              aw_hs, b_hs;
    logic              unused_hi;

    assign unused_hi = ^{mb_w[31:11], mb_h[31:11]};
    assign aw_hs     = awv_q & m_axi.awready;
    assign b_hs      = m_axi.bvalid;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        total_d = total_q;
        iss_d   = iss_q;
        cmp_d   = cmp_q;
        out_d   = out_q;
        err_d   = err_q;
        awv_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    base_d  = base_addr;
                    state_d = INIT;
                end
            end
            INIT: begin
                total_d = 22'(mb_w[10:0]) * 22'(mb_h[10:0]);
                iss_d   = '0;
                cmp_d   = '0;
                out_d   = '0;
                err_d   = b_hs;
                addr_d  = base_q;
                awv_d   = (total_d != 22'd0);
                state_d = (total_d == 22'd0) ? DONE : ISSUE;
            end
            ISSUE, DRAIN: begin
                if (aw_hs) begin
                    iss_d  = iss_q + 22'd1;
                    out_d  = out_q + 8'd1;
                    addr_d = addr_q + ADDR_W'(STRIDE);
                end
                // a response with nothing in flight is unsolicited
                if (b_hs) begin
                    if (out_q == 8'd0) begin
                        err_d = 1'b1;
                    end else begin
                        cmp_d = cmp_q + 22'd1;
                        out_d = out_d - 8'd1;
                        if (m_axi.bresp != 2'b00) err_d = 1'b1;
                    end
                end
                if (state_q == ISSUE) begin
                    awv_d = (iss_d < total_q) && (out_d < MAXO);
                    if (iss_d == total_q) state_d = DRAIN;
                end else if (cmp_d == total_q) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            total_q <= '0;
            iss_q   <= '0;
            cmp_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            awv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            total_q <= total_d;
            iss_q   <= iss_d;
            cmp_q   <= cmp_d;
            out_q   <= out_d;
            err_q   <= err_d;
            awv_q   <= awv_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = AWLEN;
    assign m_axi.awsize  = AWSIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = awv_q;
    assign m_axi.bready  = 1'b1;
    assign busy          = busy_q;
    assign done_pulse    = done_q;
    assign resp_err      = err_q;
endmodule

// File: tb/tb_wr_burst_sched.sv
// Directed bench for wr_burst_sched: address sequence, credit cap,
// empty frame, error response, simultaneous events and mid-frame reset.
module tb_wr_burst_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_pulse;
    logic [31:0] mb_w, mb_h;
    logic [63:0] base_addr;
    logic        busy, done_pulse, resp_err;
    logic        b_en;
    int          err_at;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0, start_cyc = 0, last_b = 0, done_cyc = 0;
    int aw_cnt = 0, b_cnt = 0, done_cnt = 0, awv_seen = 0, pend = 0;
    logic [63:0] aw_addr[$];
    int          aw_cyc[$];

    wr_burst_sched_if #(.ADDR_W(64)) axi ();

    wr_burst_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_pulse(start_pulse),
        .mb_w       (mb_w),
        .mb_h       (mb_h),
        .base_addr  (base_addr),
        .m_axi      (axi),
        .busy       (busy),
        .done_pulse (done_pulse),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    logic aw_hs, b_hs;
    assign aw_hs      = axi.awvalid && axi.awready;
    assign b_hs       = axi.bvalid && axi.bready;
    assign axi.bvalid = b_en && (pend > 0);
    assign axi.bresp  = (b_cnt == err_at) ? 2'b10 : 2'b00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start_pulse) start_cyc <= cyc;
        if (axi.awvalid) awv_seen <= awv_seen + 1;
        if (aw_hs) begin
            aw_cnt <= aw_cnt + 1;
            aw_addr.push_back(axi.awaddr);
            aw_cyc.push_back(cyc);
        end
        if (b_hs) begin
            b_cnt  <= b_cnt + 1;
            last_b <= cyc;
        end
        if (done_pulse) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (!rst_n) pend <= 0;
        else pend <= pend + (aw_hs ? 1 : 0) - (b_hs ? 1 : 0);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] w, input logic [31:0] h,
                         input logic [63:0] b);
        mb_w        = w;
        mb_h        = h;
        base_addr   = b;
        start_pulse = 1'b1;
        tick;
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim);
        int n = 0;
        while (done_cnt == d0 && n < lim) begin
            tick;
            n++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic wait_aw(input int target, input int lim);
        int n = 0;
        while (aw_cnt < target && n < lim) begin
            tick;
            n++;
        end
        check("aw_reached", 64'(aw_cnt >= target), 64'd1);
    endtask

    task automatic wait_b(input int target, input int lim);
        int n = 0;
        while (b_cnt < target && n < lim) begin
            tick;
            n++;
        end
        check("b_reached", 64'(b_cnt >= target), 64'd1);
    endtask

    initial begin
        logic [63:0] e1[4];
        int a0, b0, d0, v0;
        e1 = '{64'h1000, 64'h1380, 64'h1700, 64'h1a80};
        rst_n = 1'b0; start_pulse = 1'b0; mb_w = '0; mb_h = '0;
        base_addr = '0; axi.awready = 1'b0; b_en = 1'b0; err_at = -1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", 64'(axi.awvalid), 64'd0);
        check("rst_awaddr", axi.awaddr, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done_pulse), 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        check("rst_bready", 64'(axi.bready), 64'd1);
        rst_n = 1'b1;
        tick;

        // 2x2 frame, immediate ready and responses
        axi.awready = 1'b1; b_en = 1'b1;
        a0 = aw_cnt; b0 = b_cnt; d0 = done_cnt;
        start(2, 2, 64'h1000);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(d0, 100);
        check("t1_aw_count", 64'(aw_cnt - a0), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_addr%0d", i), aw_addr[a0 + i], e1[i]);
        check("t1_first_aw", 64'(aw_cyc[a0] - start_cyc), 64'd2);
        check("t1_done_lat", 64'(done_cyc - last_b), 64'd1);
        check("t1_b_count", 64'(b_cnt - b0), 64'd4);
        check("t1_err", 64'(resp_err), 64'd0);
        check("t1_awlen", 64'(axi.awlen), 64'd6);
        check("t1_awsize", 64'(axi.awsize), 64'd7);
        check("t1_awburst", 64'(axi.awburst), 64'd1);
        check("t1_idle_busy", 64'(busy), 64'd0);
        check("t1_idle_done", 64'(done_pulse), 64'd0);

        // outstanding cap with responses withheld
        b_en = 1'b0;
        a0 = aw_cnt; b0 = b_cnt; d0 = done_cnt;
        start(12, 1, 64'h10_0000);
        repeat (15) tick;
        check("t2_capped", 64'(aw_cnt - a0), 64'd8);
        check("t2_awv_low", 64'(axi.awvalid), 64'd0);
        b_en = 1'b1;
        tick;
        b_en = 1'b0;
        repeat (5) tick;
        check("t2_ninth", 64'(aw_cnt - a0), 64'd9);
        check("t2_ninth_lat", 64'(aw_cyc[a0 + 8] - last_b), 64'd1);
        check("t2_no_done", 64'(done_cnt - d0), 64'd0);
        b_en = 1'b1;
        wait_done(d0, 200);
        check("t2_aw_total", 64'(aw_cnt - a0), 64'd12);
        check("t2_b_total", 64'(b_cnt - b0), 64'd12);
        check("t2_done_lat", 64'(done_cyc - last_b), 64'd1);

        // empty frame
        a0 = aw_cnt; d0 = done_cnt; v0 = awv_seen;
        start(0, 5, 64'h2000);
        wait_done(d0, 20);
        check("t3_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        check("t3_no_awv", 64'(awv_seen - v0), 64'd0);

        // error on the second response
        a0 = aw_cnt; b0 = b_cnt; d0 = done_cnt;
        err_at = b0 + 1;
        start(3, 1, 64'h3000);
        wait_b(b0 + 1, 50);
        check("t4_err_before", 64'(resp_err), 64'd0);
        wait_b(b0 + 2, 50);
        check("t4_err_after", 64'(resp_err), 64'd1);
        wait_done(d0, 50);
        check("t4_err_held", 64'(resp_err), 64'd1);
        err_at = -1;

        // simultaneous AW and B at outstanding 7; start during ISSUE
        axi.awready = 1'b1; b_en = 1'b0;
        a0 = aw_cnt; b0 = b_cnt; d0 = done_cnt;
        start(12, 1, 64'h8000);
        tick;
        check("t5_err_clear", 64'(resp_err), 64'd0);
        wait_aw(a0 + 7, 50);
        axi.awready = 1'b0;
        tick;
        check("t5_awv_held", 64'(axi.awvalid), 64'd1);
        start(1, 1, 64'hdead_0000);
        axi.awready = 1'b1; b_en = 1'b1;
        tick;
        b_en = 1'b0;
        check("t5_awv_after", 64'(axi.awvalid), 64'd1);
        repeat (6) tick;
        check("t5_one_more", 64'(aw_cnt - a0), 64'd9);
        check("t5_awv_low", 64'(axi.awvalid), 64'd0);
        b_en = 1'b1;
        wait_done(d0, 200);
        check("t5_aw_total", 64'(aw_cnt - a0), 64'd12);
        check("t5_last_addr", aw_addr[a0 + 11], 64'ha680);

        // reset mid-frame, then a fresh 1x1 frame
        b_en = 1'b0;
        a0 = aw_cnt;
        start(6, 1, 64'h4000);
        wait_aw(a0 + 3, 50);
        rst_n = 1'b0;
        #1;
        check("t6_awvalid", 64'(axi.awvalid), 64'd0);
        check("t6_awaddr", axi.awaddr, 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_err", 64'(resp_err), 64'd0);
        check("t6_bready", 64'(axi.bready), 64'd1);
        d0 = done_cnt;
        repeat (3) tick;
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check("t6_done_low", 64'(done_pulse), 64'd0);
        rst_n = 1'b1;
        tick;
        b_en = 1'b1;
        a0 = aw_cnt; d0 = done_cnt;
        start(1, 1, 64'h2_0000_0040);
        wait_done(d0, 50);
        check("t6_aw_count", 64'(aw_cnt - a0), 64'd1);
        check("t6_addr", aw_addr[a0], 64'h2_0000_0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
